usr_spi_regs: RTL
=================

USR_SPI_REGS -- requirements
Module: usr_spi_regs

Interface
REQ-001 SHALL have parameter G_ID, default 16'hA7C1, value returned on reads of address 0x00.
REQ-002 SHALL have parameter G_CTRL_RST, default 16'h0000, reset value of the control register.
REQ-003 SHALL have port p_in_clk  input  1  system clock (sysclk25 domain); sole clock.
REQ-004 SHALL have port p_in_rst  input  1  reset, synchronous to p_in_clk, active-high.
REQ-005 SHALL have port p_in_spi_clk  input  1  usr_spi_clk pin, asynchronous, SPI mode 0.
REQ-006 SHALL have port p_in_spi_cs  input  1  usr_spi_cs[1] pin, active-low, asynchronous.
REQ-007 SHALL have port p_in_spi_mosi  input  1  usr_spi_mosi pin, asynchronous.
REQ-008 SHALL have port p_out_spi_miso  output  1  slave data out; replaces the constant-1 usr2_miso term in the top-level MISO combine.
REQ-009 SHALL have port p_in_status  input  16  status word returned on reads of address 0x03.
REQ-010 SHALL have port p_out_ctrl  output  16  control register contents.
REQ-011 SHALL have port p_out_wr_stb  output  1  one-cycle pulse on every committed write.
REQ-012 SHALL have port p_out_wr_addr  output  7  address of the last committed write.

Function
REQ-013 SHALL pass spi_clk, spi_cs and spi_mosi through 2-FF synchronizers plus one history stage; edges are detected between sync stage 2 and the history stage.
REQ-014 SHALL support SPI clock up to p_in_clk/8 (3.125 MHz at 25 MHz); faster clocks are out of scope.
REQ-015 Frame = 24 bits MSB first: bit 23 = R/W (1 = read), bits 22:16 = address, bits 15:0 = data.
REQ-016 SHALL sample mosi into the shift register on each detected spi_clk rising edge while cs is low, and increment a 5-bit bit counter.
REQ-017 Detected cs falling edge SHALL clear the bit counter and shift register (state IDLE -> CMD).
REQ-018 States: IDLE (cs high), CMD (counter 0..7), DATA (counter 8..23), DONE (counter = 24, further clocks ignored until cs rises).
REQ-019 On the 8th detected rising edge with R/W = 1, SHALL latch the read word: 0x00 -> G_ID, 0x01 -> scratch, 0x02 -> ctrl, 0x03 -> p_in_status, other addresses -> 16'h0000.
REQ-020 In a read frame, miso SHALL update on each detected spi_clk falling edge after the 8th rising edge, presenting read bits 15 down to 0, one per falling edge.
REQ-021 miso SHALL be 1 in IDLE, in CMD, during write frames, and in DONE.
REQ-022 On the 24th detected rising edge of a write frame, the addressed register (0x01 scratch, 0x02 ctrl) SHALL load bits 15:0 on that clock edge; writes to 0x00, 0x03 and unmapped addresses SHALL change no register.
REQ-023 p_out_wr_stb SHALL be high for exactly the one p_in_clk cycle after any write commit (including writes to non-writable addresses); p_out_wr_addr SHALL update on the same edge as the commit.
REQ-024 cs rising before the 24th rising edge SHALL abort the frame: no register change, no wr_stb, return to IDLE, miso = 1.
REQ-025 cs rising edge and spi_clk edge detected in the same cycle: cs takes priority; the clock edge is discarded.
REQ-026 Bits beyond 24 in one cs-low window SHALL be ignored; only one commit per frame.
REQ-027 Back-to-back frames SHALL require cs high for at least 4 p_in_clk cycles; each frame is decoded independently.

Reset
REQ-028 On p_in_rst = 1 at a p_in_clk edge: state IDLE, counter 0, shift register 0, scratch 16'h0000, p_out_ctrl = G_CTRL_RST, p_out_spi_miso = 1, p_out_wr_stb = 0, p_out_wr_addr = 0, synchronizer stages preset to cs = 1, clk = 0, mosi = 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, the block waits for a fresh cs falling edge (a cs already low at release starts no frame).

Verification
REQ-030 Read ID: frame 0x80 + 16 clocks -> miso shifts out 0xA7C1 MSB first; no wr_stb.
REQ-031 Write 0x02 = 0x1234, then read 0x02 -> p_out_ctrl = 0x1234 one cycle after the 24th edge, wr_stb single pulse, wr_addr = 0x02, read returns 0x1234.
REQ-032 Abort: write 0x01 = 0xFFFF with cs raised after 20 bits -> scratch remains 0x0000, no wr_stb, next read of 0x01 = 0x0000.
REQ-033 Status/unmapped: p_in_status = 0x5A5A, read 0x03 -> 0x5A5A; read 0x7F -> 0x0000; write 0x00 = 0xBEEF -> wr_stb pulses, G_ID unchanged.
REQ-034 Reset mid-frame: assert p_in_rst during bit 12 of a write to 0x02 -> ctrl = G_CTRL_RST, miso = 1; next full frame decodes correctly.
REQ-035 Over-length: 32 clocks writing 0x01 = 0x00AA then 0xFF.. -> scratch = 0x00AA, exactly one wr_stb.

Source files
------------

// File: rtl/usr_spi_regs.sv
// usr_spi_regs: SPI mode-0 slave register block sampled entirely in the p_in_clk domain.
// 24-bit frames (R/W, 7-bit address, 16-bit data) give access to an ID word,
// a scratch register, a control register and a status input.
module usr_spi_regs #(
    parameter logic [15:0] G_ID       = 16'hA7C1,
    parameter logic [15:0] G_CTRL_RST = 16'h0000
) (
    input  logic        p_in_clk,
    input  logic        p_in_rst,
    input  logic        p_in_spi_clk,
    input  logic        p_in_spi_cs,
    input  logic        p_in_spi_mosi,
    output logic        p_out_spi_miso,
    input  logic [15:0] p_in_status,
    output logic [15:0] p_out_ctrl,
    output logic        p_out_wr_stb,
    output logic [6:0]  p_out_wr_addr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    // Synchronizer stages (s1, s2) plus history stage (h) per SPI pin
    logic cs_s1_q,   cs_s2_q,   cs_h_q;
    logic sck_s1_q,  sck_s2_q,  sck_h_q;
    logic mosi_s1_q, mosi_s2_q, mosi_h_q;

    state_t      state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [22:0] shreg_q,   shreg_d;
    logic [15:0] rd_word_q, rd_word_d;
    logic        is_read_q, is_read_d;
    logic [15:0] scratch_q, scratch_d;
    logic [15:0] ctrl_q,    ctrl_d;
    logic        miso_q,    miso_d;
    logic        wr_stb_q,  wr_stb_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [1:0]  settle_q,  settle_d;
    logic        armed_q,   armed_d;

    logic        cs_rise, cs_fall, sck_rise, sck_fall;
    logic [23:0] frame;

    assign cs_rise  =  cs_s2_q  & ~cs_h_q;
    assign cs_fall  = ~cs_s2_q  &  cs_h_q;
    assign sck_rise =  sck_s2_q & ~sck_h_q;
    assign sck_fall = ~sck_s2_q &  sck_h_q;
    // Shift register contents with the incoming bit appended
    assign frame    = {shreg_q, mosi_h_q};

    assign p_out_spi_miso = miso_q;
    assign p_out_ctrl     = ctrl_q;
    assign p_out_wr_stb   = wr_stb_q;
    assign p_out_wr_addr  = wr_addr_q;

    // Next-state decode: frame sequencing, read-word latch, miso shifting, write commit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        rd_word_d = rd_word_q;
        is_read_d = is_read_q;
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        miso_d    = miso_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        // Frames are only accepted once cs has been seen high from real pin
        // samples after reset; the preset synchronizer value does not count.
        armed_d   = armed_q | ((settle_q == 2'd3) & cs_s2_q & cs_h_q);

        if (cs_rise) begin
            // cs release wins over any clock edge in the same cycle
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall && armed_q) begin
                        state_d   = ST_CMD;
                        cnt_d     = '0;
                        shreg_d   = '0;
                        is_read_d = 1'b0;
                        miso_d    = 1'b1;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        shreg_d = frame[22:0];
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            state_d   = ST_DATA;
                            is_read_d = frame[7];
                            if (frame[7]) begin
                                case (frame[6:0])
                                    7'h00:   rd_word_d = G_ID;
                                    7'h01:   rd_word_d = scratch_q;
                                    7'h02:   rd_word_d = ctrl_q;
                                    7'h03:   rd_word_d = p_in_status;
                                    default: rd_word_d = '0;
                                endcase
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_fall && is_read_q) begin
                        miso_d    = rd_word_q[15];
                        rd_word_d = {rd_word_q[14:0], 1'b0};
                    end else if (sck_rise) begin
                        shreg_d = frame[22:0];
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            state_d = ST_DONE;
                            miso_d  = 1'b1;
                            if (!frame[23]) begin
                                wr_stb_d  = 1'b1;
                                wr_addr_d = frame[22:16];
                                if (frame[22:16] == 7'h01) scratch_d = frame[15:0];
                                if (frame[22:16] == 7'h02) ctrl_d    = frame[15:0];
                            end
                        end
                    end
                end
                ST_DONE: begin
                    miso_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b1;
                end
            endcase
        end
    end

    // State registers and pin synchronizers, synchronous active-high reset
    always_ff @(posedge p_in_clk) begin
        if (p_in_rst) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_h_q   <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            mosi_h_q  <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            rd_word_q <= '0;
            is_read_q <= 1'b0;
            scratch_q <= '0;
            ctrl_q    <= G_CTRL_RST;
            miso_q    <= 1'b1;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            settle_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            cs_s1_q   <= p_in_spi_cs;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            sck_s1_q  <= p_in_spi_clk;
            sck_s2_q  <= sck_s1_q;
            sck_h_q   <= sck_s2_q;
            mosi_s1_q <= p_in_spi_mosi;
            mosi_s2_q <= mosi_s1_q;
            mosi_h_q  <= mosi_s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            rd_word_q <= rd_word_d;
            is_read_q <= is_read_d;
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            miso_q    <= miso_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
        end
    end

endmodule
